led_chaser: RTL and testbench



---
 rtl/led_chaser_pkg.sv | 25 ++
 rtl/led_chaser_step_tick.sv | 42 ++++
 rtl/led_chaser.sv | 146 ++++++++++++++
 tb/tb_led_chaser.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/led_chaser_pkg.sv
// led_chaser_pkg
//   Shared types and helpers for the LED chaser.
//   - mode_t       : pattern mode encoding (2 bits; value 3 is never produced)
//   - DIR_LEFT/RIGHT: direction encoding for the dir flag (1 = toward MSB)
//   - next_mode()  : mode sequence ROTATE -> BOUNCE -> JOHNSON -> ROTATE
package led_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE  = 2'd0,
    MODE_BOUNCE  = 2'd1,
    MODE_JOHNSON = 2'd2
  } mode_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_ROTATE: return MODE_BOUNCE;
      MODE_BOUNCE: return MODE_JOHNSON;
      default:     return MODE_ROTATE;
    endcase
  endfunction

endpackage

// File: rtl/led_chaser_step_tick.sv
// step_tick
//   Prescaler producing a one-cycle tick every TICK_CNT enabled cycles.
//   Ports:
//     clk  in  system clock
//     rst  in  asynchronous active-high reset (counter to 0)
//     en   in  count enable; counter is held at 0 while low
//     clr  in  synchronous clear; restarts the period from 0
//     tick out high during the last cycle of a period while enabled
module step_tick #(
  parameter int TICK_CNT = 4,
  parameter int CW       = $clog2(TICK_CNT)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last;

  assign last = (cnt_q == CW'(TICK_CNT - 1));
  assign tick = last && en;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || !en || last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// led_chaser
//   N-channel LED chaser stepping once per TICK_CNT cycles in rotate,
//   bounce or Johnson mode. Control comes from single-cycle key pulses.
//   Ports:
//     clk      in   system clock
//     rst      in   asynchronous active-high reset
//     run_p    in   pulse: toggle run/stop
//     left_p   in   pulse: direction left (toward MSB)
//     right_p  in   pulse: direction right (toward LSB); with left_p toggles
//     mode_p   in   pulse: advance mode and reload the start pattern
//     led      out  LED drive, 1 = on (registered)
//     running  out  stepping enabled (registered)
//     dir      out  1 = left, 0 = right (registered)
//     mode     out  current mode_t value (registered)
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int N_LED    = 4,
  parameter int TICK_CNT = 50_000_000,
  parameter int CW       = $clog2(TICK_CNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_p,
  input  logic             left_p,
  input  logic             right_p,
  input  logic             mode_p,
  output logic [N_LED-1:0] led,
  output logic             running,
  output logic             dir,
  output logic [1:0]       mode
);

  logic [N_LED-1:0] led_q, led_d;
  logic             running_q, running_d;
  logic             dir_q, dir_d;
  mode_t            mode_q, mode_d;

  logic tick;
  logic dir_user;
  logic bounce_flip;
  logic is_onehot;

  // Start pattern: single lit LED at the end we move away from, or all
  // dark for Johnson.
  function automatic logic [N_LED-1:0] start_pat(input mode_t m, input logic d);
    logic [N_LED-1:0] p;
    p = '0;
    if (m != MODE_JOHNSON) begin
      if (d == DIR_LEFT) p[0] = 1'b1;
      else               p[N_LED-1] = 1'b1;
    end
    return p;
  endfunction

  step_tick #(
    .TICK_CNT(TICK_CNT),
    .CW      (CW)
  ) u_step_tick (
    .clk (clk),
    .rst (rst),
    .en  (running_q),
    .clr (run_p | mode_p),
    .tick(tick)
  );

  assign is_onehot = (led_q != '0) && ((led_q & (led_q - 1'b1)) == '0);

  always_comb begin
    // Direction requested by the user this cycle (both pulses toggle).
    case ({left_p, right_p})
      2'b10:   dir_user = DIR_LEFT;
      2'b01:   dir_user = DIR_RIGHT;
      2'b11:   dir_user = ~dir_q;
      default: dir_user = dir_q;
    endcase

    running_d   = running_q ^ run_p;
    mode_d      = mode_p ? next_mode(mode_q) : mode_q;
    led_d       = led_q;
    bounce_flip = 1'b0;

    // Reload outranks a step; a run toggle in a tick cycle discards the step.
    // Steps use the registered direction so a pulse acts from the next tick.
    if (mode_p) begin
      led_d = start_pat(mode_d, dir_user);
    end else if (tick && !run_p) begin
      case (mode_q)
        MODE_ROTATE: begin
          if (!is_onehot)            led_d = start_pat(mode_q, dir_q);
          else if (dir_q == DIR_LEFT) led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
          else                       led_d = {led_q[0], led_q[N_LED-1:1]};
        end
        MODE_BOUNCE: begin
          if (!is_onehot) begin
            led_d = start_pat(mode_q, dir_q);
          end else if (dir_q == DIR_LEFT) begin
            if (led_q[N_LED-1]) begin
              bounce_flip = 1'b1;
              led_d       = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              bounce_flip = 1'b1;
              led_d       = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        MODE_JOHNSON: begin
          if (dir_q == DIR_LEFT) led_d = {led_q[N_LED-2:0], ~led_q[N_LED-1]};
          else                   led_d = {~led_q[0], led_q[N_LED-1:1]};
        end
        default: led_d = led_q;
      endcase
    end

    // A user pulse wins over the automatic bounce reversal.
    if (left_p || right_p) dir_d = dir_user;
    else if (bounce_flip)  dir_d = ~dir_q;
    else                   dir_d = dir_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q     <= N_LED'(1);
      running_q <= 1'b1;
      dir_q     <= DIR_LEFT;
      mode_q    <= MODE_ROTATE;
    end else begin
      led_q     <= led_d;
      running_q <= running_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
    end
  end

  assign led     = led_q;
  assign running = running_q;
  assign dir     = dir_q;
  assign mode    = mode_q;

endmodule

// File: tb/tb_led_chaser.sv
module tb_led_chaser;

  localparam int N = 4;
  localparam int T = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run_p = 1'b0, left_p = 1'b0, right_p = 1'b0, mode_p = 1'b0;
  logic [N-1:0] led;
  logic         running, dir;
  logic [1:0]   mode;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model: lit position for one-hot modes, integer pattern,
  // step counter for the prescaler.
  int m_led, m_pos, m_run, m_dir, m_mode, m_cnt;

  led_chaser #(.N_LED(N), .TICK_CNT(T)) dut (
    .clk    (clk),
    .rst    (rst),
    .run_p  (run_p),
    .left_p (left_p),
    .right_p(right_p),
    .mode_p (mode_p),
    .led    (led),
    .running(running),
    .dir    (dir),
    .mode   (mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_led = 1; m_run = 1; m_dir = 1; m_mode = 0; m_cnt = 0;
  endtask

  task automatic model_reload(input int d);
    if (m_mode == 2) begin
      m_led = 0;
    end else begin
      m_pos = d ? 0 : N - 1;
      m_led = 1 << m_pos;
    end
  endtask

  task automatic model_edge(input bit rp, input bit lp, input bit rtp, input bit mp);
    bit tick;
    int nd, ad;
    tick = (m_run != 0) && (m_cnt == T - 1);
    nd = m_dir;
    if (lp && rtp) nd = 1 - m_dir;
    else if (lp)   nd = 1;
    else if (rtp)  nd = 0;
    if (mp) begin
      m_mode = (m_mode + 1) % 3;
      m_dir  = nd;
      model_reload(nd);
    end else if (tick && !rp) begin
      if (m_mode == 0) begin
        m_pos = m_dir ? (m_pos + 1) % N : (m_pos + N - 1) % N;
        m_led = 1 << m_pos;
        m_dir = nd;
      end else if (m_mode == 1) begin
        ad = m_dir;
        if ((m_dir == 1 && m_pos == N - 1) || (m_dir == 0 && m_pos == 0)) ad = 1 - m_dir;
        m_pos = ad ? m_pos + 1 : m_pos - 1;
        m_led = 1 << m_pos;
        m_dir = (lp || rtp) ? nd : ad;
      end else begin
        if (m_dir) m_led = ((m_led << 1) & MASK) | (((m_led >> (N - 1)) & 1) ^ 1);
        else       m_led = (m_led >> 1) | (((m_led & 1) ^ 1) << (N - 1));
        m_dir = nd;
      end
    end else begin
      m_dir = nd;
    end
    if (rp || mp || m_run == 0) m_cnt = 0;
    else                        m_cnt = (m_cnt + 1) % T;
    if (rp) m_run = 1 - m_run;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_led"},  32'(led),     m_led);
    chk({tag, "_run"},  32'(running), m_run);
    chk({tag, "_dir"},  32'(dir),     m_dir);
    chk({tag, "_mode"}, 32'(mode),    m_mode);
  endtask

  task automatic cyc(input string tag, input bit rp = 0, input bit lp = 0,
                     input bit rtp = 0, input bit mp = 0);
    run_p = rp; left_p = lp; right_p = rtp; mode_p = mp;
    @(posedge clk);
    model_edge(rp, lp, rtp, mp);
    #1;
    run_p = 0; left_p = 0; right_p = 0; mode_p = 0;
    check_all(tag);
  endtask

  initial begin
    logic [N-1:0] held;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led",  32'(led),     1);
    chk("rst_run",  32'(running), 1);
    chk("rst_dir",  32'(dir),     1);
    chk("rst_mode", 32'(mode),    0);
    rst = 1'b0;

    // 1: rotate left after reset
    for (int i = 1; i <= 16; i++) begin
      cyc("s1");
      if (i == 3)  chk("s1_before_first", 32'(led), 1);
      if (i == 4)  chk("s1_first_step",   32'(led), 2);
      if (i == 12) chk("s1_msb",          32'(led), 8);
      if (i == 16) chk("s1_wrap",         32'(led), 1);
    end

    // 2: direction pulses
    for (int i = 0; i < 8; i++) cyc("s2a");
    chk("s2_at_0100", 32'(led), 4);
    cyc("s2_right", 0, 0, 1, 0);
    chk("s2_dir_right", 32'(dir), 0);
    for (int i = 0; i < 11; i++) cyc("s2b");
    chk("s2_wrap_right", 32'(led), 8);
    cyc("s2_both", 0, 1, 1, 0);
    chk("s2_both_dir", 32'(dir), 1);
    for (int i = 0; i < 3; i++) cyc("s2c");
    chk("s2_left_wrap", 32'(led), 1);

    // 3: bounce
    cyc("s3_mode", 0, 0, 0, 1);
    chk("s3_mode_bounce", 32'(mode), 1);
    chk("s3_reload", 32'(led), 1);
    for (int i = 1; i <= 28; i++) begin
      cyc("s3");
      if (i == 12) chk("s3_top",       32'(led), 8);
      if (i == 16) chk("s3_flip_led",  32'(led), 4);
      if (i == 16) chk("s3_flip_dir",  32'(dir), 0);
      if (i == 28) chk("s3_reflip",    32'(led), 2);
      if (i == 28) chk("s3_reflip_dir", 32'(dir), 1);
    end

    // 4: Johnson
    cyc("s4_mode", 0, 0, 0, 1);
    chk("s4_mode_johnson", 32'(mode), 2);
    chk("s4_zero", 32'(led), 0);
    for (int i = 1; i <= 32; i++) begin
      cyc("s4");
      if (i == 4)  chk("s4_one",   32'(led), 1);
      if (i == 16) chk("s4_full",  32'(led), 15);
      if (i == 20) chk("s4_e",     32'(led), 14);
      if (i == 32) chk("s4_cycle", 32'(led), 0);
    end

    // 5: stop / resume
    cyc("s5a");
    cyc("s5b");
    cyc("s5_stop", 1, 0, 0, 0);
    held = led;
    chk("s5_stopped", 32'(running), 0);
    for (int i = 0; i < 20; i++) cyc("s5_hold");
    chk("s5_frozen", 32'(led), 32'(held));
    cyc("s5_resume", 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc("s5_run");
      if (i == 3) chk("s5_not_yet", 32'(led), 32'(held));
      if (i == 4) chk("s5_stepped", 32'(led !== held), 1);
    end

    // 6: mode_p coinciding with tick, then async reset mid-cycle
    cyc("s6_rot", 0, 0, 0, 1);
    for (int k = 0; k < 2 * T && !(m_run != 0 && m_cnt == T - 1); k++) cyc("s6_wait");
    cyc("s6_mode_tick", 0, 0, 0, 1);
    chk("s6_bounce_mode", 32'(mode), 1);
    chk("s6_start_pat", 32'(led), dir ? 1 : 8);
    cyc("s6a", 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc("s6b");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("s6_rst_led",  32'(led),     1);
    chk("s6_rst_mode", 32'(mode),    0);
    chk("s6_rst_dir",  32'(dir),     1);
    chk("s6_rst_run",  32'(running), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized pulses against the model
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
